uart_rx_deframer: RTL and testbench
===================================

# uart_rx_deframer

Receive-side deframer of the UART: takes the serial line produced by the transmitter (tx_line, looped back or external), recovers 8-N-1 frames by 16x oversampling, and writes each good byte into the RX FIFO with a one-cycle write strobe. It sits directly downstream of the TX serializer and directly upstream of the RX FIFO write port (winc_rxFIFO / data_rx_uart).

## Interface
- BAUD_DIV, 27: clk_main cycles per oversample tick (bit period = 16*BAUD_DIV cycles; 27 gives about 115200 baud at 50 MHz); legal range 2..4095.
- clk_main  input  1  single system clock, all logic on its rising edge.
- reset  input  1  asynchronous, active-low; all state and outputs cleared while low.
- rx_line  input  1  serial input, idle high, asynchronous to clk_main.
- rx_fifo_full  input  1  RX FIFO full flag.
- rx_data  output  8  last received byte, LSB first on line; reset 8'h00.
- rx_valid  output  1  one-cycle write strobe to RX FIFO; reset 0.
- frame_err  output  1  one-cycle pulse, stop bit sampled 0; reset 0.
- overrun  output  1  one-cycle pulse, good byte dropped because FIFO full; reset 0.
- rx_busy  output  1  high from start detect until return to IDLE; reset 0.
- rx_frame_mon  output  10  last captured frame {stop, data[7:0], start}; reset 10'h000.
- parity_err  output  1  present only with UART_RX_PARITY_EN; one-cycle pulse; reset 0.

## Operation
- rx_line passes through a 2-flop synchronizer, reset to 1; rx_s is the second flop output.
- Tick generator: a 12-bit counter counts 0..BAUD_DIV-1 and emits tick on the terminal count. It is held at 0 in IDLE and restarts on start detect.
- States:
  - IDLE: wait for rx_s==0 while the previous rx_s==1 (falling edge). Clear the 4-bit tick count and go to START.
  - START: on tick 8 sample rx_s. If 1, treat as a glitch and return to IDLE with no pulse. If 0, go to DATA with the bit index at 0.
  - DATA: every 16 ticks sample rx_s into shift[bit index]. After bit 7 go to STOP (or PARITY when compiled in).
  - STOP: sample 16 ticks later.
    - rx_s==1 and rx_fifo_full==0: load rx_data, pulse rx_valid.
    - rx_s==1 and rx_fifo_full==1: pulse overrun. rx_data and rx_valid are not updated.
    - rx_s==0: pulse frame_err. No rx_valid.
    - Every case: update rx_frame_mon, then go to IDLE.
- Return to IDLE at stop mid-bit, so back-to-back frames work. A start edge requires rx_s to have been high first, so a break (line held low) produces exactly one frame_err and no further frames until the line goes high.
- Reset asserted mid-frame aborts immediately. After release the block waits in IDLE; the partial frame produces no pulse.

## Timing
- Samples fall at ticks 8+16k relative to the synced falling edge (k=0 start, 1..8 data, 9 stop).
- rx_valid, frame_err and overrun are registered. They assert exactly 152*BAUD_DIV+1 clk_main cycles after the cycle where rx_s first reads 0; with parity the figure is 168*BAUD_DIV+1.
- rx_line to rx_s latency is 2 cycles.
- All pulses are exactly one cycle wide. At most one of rx_valid, frame_err, overrun, parity_err is high per frame, except that parity_err may accompany frame_err.
- rx_busy deasserts in the same cycle the result pulse asserts.

## Configuration
- UART_RX_PARITY_EN defined:
  - Adds a PARITY state between DATA and STOP that samples an even-parity bit; stop is sampled 16 ticks later.
  - A mismatch pulses parity_err together with the stop result and suppresses rx_valid.
  - rx_frame_mon widens to 11 bits {stop, parity, data, start}.
- UART_RX_PARITY_EN undefined: 8-N-1 frames only. The parity_err port and PARITY state do not exist.

## Test plan
- BAUD_DIV=4: send the frame for 8'hD3 with the line held high before and after -> one rx_valid at 609 cycles after the synced edge, rx_data=8'hD3, rx_frame_mon=10'b1_11010011_0.
- Two back-to-back frames 8'hD3 then 8'hF0 with no idle gap -> two rx_valid pulses 160*BAUD_DIV cycles apart, with rx_data 8'hD3 then 8'hF0.
- 6-cycle low glitch on rx_line (BAUD_DIV=4) -> rx_busy pulses, then returns to IDLE; no rx_valid, no frame_err.
- Frame 8'h55 with stop bit 0, line then held low for 40 bit times -> exactly one frame_err, no rx_valid; the next proper frame after the line returns high is received.
- rx_fifo_full=1 during frame 8'hA5 -> overrun pulse, no rx_valid, rx_data keeps its previous value.
- Reset low for 3 cycles in the middle of data bit 4, then a full 8'h3C frame -> no pulse for the aborted frame, rx_data=8'h3C. With UART_RX_PARITY_EN, a wrong parity bit on 8'h3C -> parity_err and no rx_valid.

Source files
------------

// File: rtl/uart_rx_deframer.sv
// UART 8-N-1 receive deframer with 16x oversampling; optional even parity via UART_RX_PARITY_EN.
// Latency: result pulse 152*BAUD_DIV+1 cycles after synced start edge (168*BAUD_DIV+1 with parity).
// Backpressure: none on the line; a good byte arriving while rx_fifo_full is dropped with an overrun pulse.
module uart_rx_deframer #(
    parameter int BAUD_DIV = 27
) (
    input  logic        clk_main,
    input  logic        reset,
    input  logic        rx_line,
    input  logic        rx_fifo_full,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        frame_err,
    output logic        overrun,
    output logic        rx_busy,
`ifdef UART_RX_PARITY_EN
    output logic [10:0] rx_frame_mon,
    output logic        parity_err
`else
    output logic [9:0]  rx_frame_mon
`endif
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd4;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd3;
`endif

    localparam logic [11:0] BAUD_LAST = 12'(BAUD_DIV - 1);

    logic [2:0]  state;
    logic        rx_meta;
    logic        rx_s;
    logic        rx_s_prev;
    logic [11:0] baud_cnt;
    logic        tick;
    logic [3:0]  tick_cnt;
    logic [3:0]  tick_last;
    logic        mid_bit;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic        start_bit;
`ifdef UART_RX_PARITY_EN
    logic        parity_bit;
    logic        par_bad;

    assign par_bad = parity_bit ^ (^shift);
`endif

    // Synchronizer resets to idle-high so releasing reset never fakes a start edge.
    always_ff @(posedge clk_main or negedge reset) begin
        if (!reset) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            rx_s_prev <= 1'b1;
        end else begin
            rx_meta   <= rx_line;
            rx_s      <= rx_meta;
            rx_s_prev <= rx_s;
        end
    end

    assign tick = (state != ST_IDLE) && (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk_main or negedge reset) begin
        if (!reset) begin
            baud_cnt <= 12'd0;
        end else if (state == ST_IDLE || tick) begin
            baud_cnt <= 12'd0;
        end else begin
            baud_cnt <= baud_cnt + 12'd1;
        end
    end

    // Start bit is checked half a bit in; every later sample is a full bit after the previous one.
    assign tick_last = (state == ST_START) ? 4'd7 : 4'd15;
    assign mid_bit   = tick && (tick_cnt == tick_last);
    assign rx_busy   = (state != ST_IDLE);

    always_ff @(posedge clk_main or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            tick_cnt     <= 4'd0;
            bit_idx      <= 3'd0;
            shift        <= 8'h00;
            start_bit    <= 1'b0;
            rx_data      <= 8'h00;
            rx_valid     <= 1'b0;
            frame_err    <= 1'b0;
            overrun      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bit   <= 1'b0;
            parity_err   <= 1'b0;
            rx_frame_mon <= 11'h000;
`else
            rx_frame_mon <= 10'h000;
`endif
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (state == ST_IDLE) begin
                tick_cnt <= 4'd0;
            end else if (tick) begin
                tick_cnt <= mid_bit ? 4'd0 : tick_cnt + 4'd1;
            end

            case (state)
                ST_IDLE: begin
                    if (!rx_s && rx_s_prev) begin
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (mid_bit) begin
                        if (rx_s) begin
                            state <= ST_IDLE;
                        end else begin
                            start_bit <= rx_s;
                            bit_idx   <= 3'd0;
                            state     <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (mid_bit) begin
                        shift[bit_idx] <= rx_s;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (mid_bit) begin
                        parity_bit <= rx_s;
                        state      <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    // Leave at stop mid-bit so a back-to-back start edge is not missed.
                    if (mid_bit) begin
                        state <= ST_IDLE;
`ifdef UART_RX_PARITY_EN
                        rx_frame_mon <= {rx_s, parity_bit, shift, start_bit};
                        parity_err   <= par_bad;
                        if (!rx_s) begin
                            frame_err <= 1'b1;
                        end else if (!par_bad) begin
                            if (rx_fifo_full) begin
                                overrun <= 1'b1;
                            end else begin
                                rx_data  <= shift;
                                rx_valid <= 1'b1;
                            end
                        end
`else
                        rx_frame_mon <= {rx_s, shift, start_bit};
                        if (!rx_s) begin
                            frame_err <= 1'b1;
                        end else if (rx_fifo_full) begin
                            overrun <= 1'b1;
                        end else begin
                            rx_data  <= shift;
                            rx_valid <= 1'b1;
                        end
`endif
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Scoreboard bench for uart_rx_deframer at BAUD_DIV=4: directed frames, glitch, break, overrun, mid-frame reset.
module tb_uart_rx_deframer;

    localparam int B   = 4;
    localparam int BIT = 16 * B;
`ifdef UART_RX_PARITY_EN
    localparam int FB  = 11;
    localparam int LAT = 168 * B + 1;
`else
    localparam int FB  = 10;
    localparam int LAT = 152 * B + 1;
`endif

    typedef logic [FB-1:0] mon_t;
    typedef struct {
        logic [3:0] kind;
        logic [7:0] data;
        mon_t       mon;
        int         at;
    } exp_t;

    logic        clk_main = 1'b0;
    logic        reset = 1'b0;
    logic        rx_line = 1'b1;
    logic        rx_fifo_full = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        frame_err;
    logic        overrun;
    logic        rx_busy;
    mon_t        rx_frame_mon;
    logic        perr;

    uart_rx_deframer #(.BAUD_DIV(B)) dut (
        .clk_main     (clk_main),
        .reset        (reset),
        .rx_line      (rx_line),
        .rx_fifo_full (rx_fifo_full),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .frame_err    (frame_err),
        .overrun      (overrun),
        .rx_busy      (rx_busy),
`ifdef UART_RX_PARITY_EN
        .rx_frame_mon (rx_frame_mon),
        .parity_err   (perr)
`else
        .rx_frame_mon (rx_frame_mon)
`endif
    );
`ifndef UART_RX_PARITY_EN
    assign perr = 1'b0;
`endif

    always #5 clk_main = ~clk_main;

    int cyc = 0;
    always @(posedge clk_main) cyc <= cyc + 1;

    int   n_chk = 0;
    int   n_fail = 0;
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Frame bits LSB first on the line: {stop, [parity,] data, start}.
    function automatic mon_t mk(input logic [7:0] d, input logic stop, input logic pflip);
`ifdef UART_RX_PARITY_EN
        return {stop, (^d) ^ pflip, d, 1'b0};
`else
        return {stop, d, 1'b0};
`endif
    endfunction

    task automatic drive(input logic b, input int n);
        rx_line = b;
        repeat (n) @(posedge clk_main);
        #1;
    endtask

    task automatic send(input mon_t f);
        for (int i = 0; i < FB; i++) drive(f[i], BIT);
    endtask

    task automatic expect_ev(input logic [3:0] kind, input logic [7:0] data, input mon_t f, input int start);
        exp_t e;
        e.kind = kind;
        e.data = data;
        e.mon  = f;
        e.at   = start + 2 + LAT;
        sb.push_back(e);
    endtask

    logic prev_busy = 1'b0;
    always @(negedge clk_main) begin : monitor
        logic [3:0] k;
        exp_t       e;
        k = {perr, overrun, frame_err, rx_valid};
        if (k != 4'b0000) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", {28'd0, k}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("pulse_kind", {28'd0, k}, {28'd0, e.kind});
                check("rx_data", {24'd0, rx_data}, {24'd0, e.data});
                check("rx_frame_mon", 32'(rx_frame_mon), 32'(e.mon));
                check("pulse_cycle", cyc, e.at);
                check("busy_drop", {30'd0, prev_busy, rx_busy}, 32'd2);
            end
        end
        prev_busy = rx_busy;
    end

    initial begin
        mon_t f;
        mon_t f2;
        int   n;

        repeat (3) @(posedge clk_main);
        #1;
        check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        check("rst_rx_busy", {31'd0, rx_busy}, 32'd0);
        check("rst_rx_data", {24'd0, rx_data}, 32'd0);
        check("rst_frame_mon", 32'(rx_frame_mon), 32'd0);
        reset = 1'b1;
        drive(1'b1, 2 * BIT);

        // Single frame D3
        f = mk(8'hD3, 1'b1, 1'b0);
        expect_ev(4'b0001, 8'hD3, f, cyc);
        send(f);
        drive(1'b1, 2 * BIT);

        // Back-to-back D3, F0
        f  = mk(8'hD3, 1'b1, 1'b0);
        f2 = mk(8'hF0, 1'b1, 1'b0);
        n  = cyc;
        expect_ev(4'b0001, 8'hD3, f, n);
        expect_ev(4'b0001, 8'hF0, f2, n + FB * BIT);
        send(f);
        send(f2);
        drive(1'b1, 2 * BIT);

        // 6-cycle glitch
        drive(1'b0, 6);
        drive(1'b1, 4);
        check("glitch_busy_high", {31'd0, rx_busy}, 32'd1);
        drive(1'b1, 40);
        check("glitch_busy_low", {31'd0, rx_busy}, 32'd0);
        drive(1'b1, 2 * BIT);

        // Bad stop bit followed by a long break, then a good frame
        f = mk(8'h55, 1'b0, 1'b0);
        expect_ev(4'b0010, 8'hF0, f, cyc);
        send(f);
        drive(1'b0, 40 * BIT);
        drive(1'b1, 2 * BIT);
        f = mk(8'h81, 1'b1, 1'b0);
        expect_ev(4'b0001, 8'h81, f, cyc);
        send(f);
        drive(1'b1, 2 * BIT);

        // FIFO full during A5
        rx_fifo_full = 1'b1;
        f = mk(8'hA5, 1'b1, 1'b0);
        expect_ev(4'b0100, 8'h81, f, cyc);
        send(f);
        drive(1'b1, BIT);
        rx_fifo_full = 1'b0;
        check("overrun_keeps_data", {24'd0, rx_data}, 32'h81);
        drive(1'b1, BIT);

        // Reset in the middle of data bit 4, then a full 3C frame
        f = mk(8'h3C, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) drive(f[i], BIT);
        drive(f[5], BIT / 2);
        reset = 1'b0;
        drive(f[5], 3);
        check("midrst_busy", {31'd0, rx_busy}, 32'd0);
        check("midrst_data", {24'd0, rx_data}, 32'd0);
        reset = 1'b1;
        drive(1'b1, 3 * BIT);
        expect_ev(4'b0001, 8'h3C, f, cyc);
        send(f);
        drive(1'b1, 2 * BIT);

`ifdef UART_RX_PARITY_EN
        f = mk(8'h3C, 1'b1, 1'b1);
        expect_ev(4'b1000, 8'h3C, f, cyc);
        send(f);
        drive(1'b1, 2 * BIT);
`endif

        drive(1'b1, BIT);
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
